or_merge_pipe: RTL and testbench

Parametrised elastic pipeline that delays a WIDTH-bit data beat `d` through DEPTH register stages and merges it by bitwise OR with a side operand `a` on entry to the last stage. It generalises the fixed two-flop delay-then-OR cell by adding:
- configurable width and depth;
- valid/ready flow control with bubble collapsing;
- a synchronous flush;
- an in-flight beat counter.

It sits between a producer and a consumer in the datapath, wherever a delayed flag or vector must be OR-combined with a later-arriving qualifier.

---
 rtl/or_merge_pipe_pkg.sv | 17 +
 rtl/or_merge_pipe_if.sv | 28 ++
 rtl/or_merge_pipe_stage.sv | 23 ++
 rtl/or_merge_pipe.sv | 120 ++++++++++++
 tb/tb_or_merge_pipe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/or_merge_pipe_pkg.sv
// Shared defaults, counter width helper and side-operand sampling mode
// for the OR-merge pipeline.
package simple_pipe_pkg;

   localparam int unsigned DEF_WIDTH = 1;
   localparam int unsigned DEF_DEPTH = 2;

   typedef enum logic {
      A_LATE  = 1'b0,
      A_EARLY = 1'b1
   } a_sample_e;

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/or_merge_pipe_if.sv
// Producer/consumer handshake bundle for or_merge_pipe; the pipeline
// itself connects through the slave modport.
interface or_merge_pipe_if
   import simple_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
);
   logic                      sclr;
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          d;
   logic [WIDTH-1:0]          a;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          y;
   logic [cnt_w(DEPTH)-1:0]   count;

   modport master (
      output sclr, in_valid, d, a, out_ready,
      input  in_ready, out_valid, y, count
   );

   modport slave (
      input  sclr, in_valid, d, a, out_ready,
      output in_ready, out_valid, y, count
   );
endinterface

// File: rtl/or_merge_pipe_stage.sv
// pipe_stage: WIDTH-bit register with load enable and asynchronous
// active-low clear.
module pipe_stage #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;
endmodule

// File: rtl/or_merge_pipe.sv
// or_merge_pipe: elastic DEPTH-stage delay of d, OR-merged with a on entry
// to the output stage; valid/ready with bubble collapsing, flush and count.
module or_merge_pipe
   import simple_pipe_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter a_sample_e   A_SAMPLE = A_LATE
) (
   input logic            clk,
   input logic            rst,
   or_merge_pipe_if.slave bus
);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [DEPTH-1:0] r_vld;
   logic [CW-1:0]    r_cnt;
   logic [DEPTH-1:0] w_adv;
   logic [DEPTH-1:0] w_up_vld;
   logic [DEPTH-1:0] w_ld;
   logic [WIDTH-1:0] w_up_dat [DEPTH];
   logic [WIDTH-1:0] w_up_aux [DEPTH];
   logic [WIDTH-1:0] w_mrg;
   logic [WIDTH-1:0] w_y;
   logic             w_acc;
   logic             w_hs;

   // adv[i] = out_ready | ~&vld[DEPTH-1:i]; the unrolled form of the ripple chain
   always_comb begin
      logic l_all;
      w_adv = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         l_all = 1'b1;
         for (int unsigned j = i; j < DEPTH; j++) begin
            l_all = l_all & r_vld[j];
         end
         w_adv[i] = bus.out_ready | ~l_all;
      end
   end

   assign bus.in_ready = w_adv[0] & ~bus.sclr & rst;
   assign w_acc        = bus.in_valid & bus.in_ready;
   assign w_hs         = r_vld[DEPTH-1] & bus.out_ready;

   always_comb begin
      w_up_vld    = '0;
      w_up_vld[0] = w_acc;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         w_up_vld[i] = r_vld[i-1];
      end
   end

   // Data only moves with a valid beat so y holds its last value when empty
   assign w_ld        = w_adv & w_up_vld & {DEPTH{~bus.sclr}};
   assign w_up_dat[0] = bus.d;
   assign w_up_aux[0] = bus.a;
   assign w_mrg       = w_up_dat[DEPTH-1] |
                        ((A_SAMPLE == A_EARLY) ? w_up_aux[DEPTH-1] : bus.a);

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == DEPTH - 1) begin : g_last
         pipe_stage #(.WIDTH(WIDTH)) u_dat (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_en    (w_ld[i]),
            .i_d     (w_mrg),
            .o_q     (w_y)
         );
      end else begin : g_mid
         pipe_stage #(.WIDTH(WIDTH)) u_dat (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_en    (w_ld[i]),
            .i_d     (w_up_dat[i]),
            .o_q     (w_up_dat[i+1])
         );
         if (A_SAMPLE == A_EARLY) begin : g_aux
            pipe_stage #(.WIDTH(WIDTH)) u_aux (
               .i_clk   (clk),
               .i_rst_n (rst),
               .i_en    (w_ld[i]),
               .i_d     (w_up_aux[i]),
               .o_q     (w_up_aux[i+1])
            );
         end else begin : g_noaux
            assign w_up_aux[i+1] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld <= '0;
      end else if (bus.sclr) begin
         r_vld <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_adv[i]) begin
               r_vld[i] <= w_up_vld[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (bus.sclr) begin
         r_cnt <= '0;
      end else if (w_acc && !w_hs) begin
         r_cnt <= r_cnt + CW'(1);
      end else if (w_hs && !w_acc) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign bus.y         = w_y;
   assign bus.out_valid = r_vld[DEPTH-1];
   assign bus.count     = r_cnt;
endmodule

// File: tb/tb_or_merge_pipe.sv
// Scoreboard bench for or_merge_pipe: directed vectors on a DEPTH=2 late-join
// instance plus DEPTH=1 and DEPTH=4 early-join instances.
module tb_or_merge_pipe;
   import simple_pipe_pkg::*;

   typedef struct {
      logic [3:0] y;
      int         cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_fail;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q4[$];

   or_merge_pipe_if #(.WIDTH(4), .DEPTH(2)) bus0 ();
   or_merge_pipe_if #(.WIDTH(4), .DEPTH(1)) bus1 ();
   or_merge_pipe_if #(.WIDTH(4), .DEPTH(4)) bus4 ();

   or_merge_pipe #(.WIDTH(4), .DEPTH(2), .A_SAMPLE(A_LATE)) u_dut0 (
      .clk (clk), .rst (rst_n), .bus (bus0)
   );
   or_merge_pipe #(.WIDTH(4), .DEPTH(1), .A_SAMPLE(A_EARLY)) u_dut1 (
      .clk (clk), .rst (rst_n), .bus (bus1)
   );
   or_merge_pipe #(.WIDTH(4), .DEPTH(4), .A_SAMPLE(A_EARLY)) u_dut4 (
      .clk (clk), .rst (rst_n), .bus (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus0.out_valid && bus0.out_ready) begin
         if (q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL out0_unexpected: got y=%0h, expected no output", bus0.y);
         end else begin
            e = q0.pop_front();
            chk("y0", 32'(bus0.y), 32'(e.y));
            if (e.cyc >= 0) chk("lat0", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus1.out_valid && bus1.out_ready) begin
         if (q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL out1_unexpected: got y=%0h, expected no output", bus1.y);
         end else begin
            e = q1.pop_front();
            chk("y1", 32'(bus1.y), 32'(e.y));
            chk("lat1", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus4.out_valid && bus4.out_ready) begin
         if (q4.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL out4_unexpected: got y=%0h, expected no output", bus4.y);
         end else begin
            e = q4.pop_front();
            chk("y4", 32'(bus4.y), 32'(e.y));
            chk("lat4", cyc, e.cyc);
         end
      end
   end

   // One cycle on the DEPTH=2 instance; called and returns at posedge+1
   task automatic step0(input logic iv, input logic [3:0] dv, input logic [3:0] av,
                        input logic ordy, input logic sc, input logic [3:0] ey,
                        input logic lat, input logic eacc);
      logic acc;
      exp_t e;
      bus0.in_valid  = iv;
      bus0.d         = dv;
      bus0.a         = av;
      bus0.out_ready = ordy;
      bus0.sclr      = sc;
      @(negedge clk);
      acc = iv & bus0.in_ready;
      if (iv) chk("accept0", 32'(acc), 32'(eacc));
      if (acc) begin
         e.y   = ey;
         e.cyc = lat ? cyc + 2 : -1;
         q0.push_back(e);
      end
      @(posedge clk); #1;
      if (sc) q0.delete();
   endtask

   task automatic step14(input logic iv, input logic [3:0] dv, input logic [3:0] av,
                         input logic [3:0] ey);
      exp_t e;
      bus1.in_valid = iv; bus1.d = dv; bus1.a = av;
      bus4.in_valid = iv; bus4.d = dv; bus4.a = av;
      @(negedge clk);
      if (iv) begin
         chk("accept1", 32'(bus1.in_ready), 32'd1);
         chk("accept4", 32'(bus4.in_ready), 32'd1);
         e.y = ey;
         if (bus1.in_ready) begin e.cyc = cyc + 1; q1.push_back(e); end
         if (bus4.in_ready) begin e.cyc = cyc + 4; q4.push_back(e); end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      bus0.sclr = 1'b0; bus0.in_valid = 1'b0; bus0.d = '0; bus0.a = '0; bus0.out_ready = 1'b1;
      bus1.sclr = 1'b0; bus1.in_valid = 1'b0; bus1.d = '0; bus1.a = '0; bus1.out_ready = 1'b1;
      bus4.sclr = 1'b0; bus4.in_valid = 1'b0; bus4.d = '0; bus4.a = '0; bus4.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus0.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
      chk("rst_y", 32'(bus0.y), 32'd0);
      chk("rst_count", 32'(bus0.count), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(bus0.in_ready), 32'd1);
      @(posedge clk); #1;

      // Streaming, late join: a=8 in the second cycle merges into the first beat
      step0(1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 4'h9, 1'b1, 1'b1);
      step0(1'b1, 4'h2, 4'h8, 1'b1, 1'b0, 4'h2, 1'b1, 1'b1);
      step0(1'b1, 4'h4, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1);
      step0(1'b1, 4'h8, 4'h0, 1'b1, 1'b0, 4'h8, 1'b1, 1'b1);
      repeat (3) step0(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("drain_count", 32'(bus0.count), 32'd0);
      chk("drain_out_valid", 32'(bus0.out_valid), 32'd0);
      chk("hold_y", 32'(bus0.y), 32'h8);

      // Backpressure and full-with-drain
      step0(1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b1);
      step0(1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1);
      step0(1'b1, 4'h6, 4'h0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
      chk("full_count", 32'(bus0.count), 32'd2);
      step0(1'b1, 4'h6, 4'h0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b1);
      chk("full_drain_count", 32'(bus0.count), 32'd2);
      repeat (3) step0(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("bp_count", 32'(bus0.count), 32'd0);

      // Flush with a simultaneous input beat
      step0(1'b1, 4'hA, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1);
      step0(1'b1, 4'hB, 4'h0, 1'b0, 1'b0, 4'hB, 1'b0, 1'b1);
      chk("pre_flush_count", 32'(bus0.count), 32'd2);
      step0(1'b1, 4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
      chk("flush_out_valid", 32'(bus0.out_valid), 32'd0);
      chk("flush_count", 32'(bus0.count), 32'd0);
      chk("flush_y_kept", 32'(bus0.y), 32'hA);
      repeat (3) step0(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

      // Reset mid-stream
      step0(1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1);
      step0(1'b1, 4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b1);
      bus0.in_valid = 1'b0;
      chk("pre_rst_out_valid", 32'(bus0.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(bus0.out_valid), 32'd0);
      chk("async_rst_count", 32'(bus0.count), 32'd0);
      chk("async_rst_y", 32'(bus0.y), 32'd0);
      q0.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rerst_in_ready", 32'(bus0.in_ready), 32'd1);
      @(posedge clk); #1;
      repeat (4) step0(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

      // Early join at DEPTH=1 and DEPTH=4; a after acceptance must not leak in
      step14(1'b1, 4'h1, 4'h2, 4'h3);
      step14(1'b0, 4'h0, 4'hC, 4'h0);
      step14(1'b1, 4'h4, 4'h8, 4'hC);
      step14(1'b0, 4'h0, 4'h3, 4'h0);
      repeat (6) step14(1'b0, 4'h0, 4'h0, 4'h0);

      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      chk("q4_empty", 32'(q4.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
